// File: rtl/serial_rx_8.sv
// Serial-in/parallel-out receiver: reassembles MSB-first words from a qualified
// bit stream, checks optional even parity and flags frames cut short by an early sof.
module serial_rx_8 #(
   parameter int DATA_W    = 8,
   parameter bit PARITY_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_in,
   input  logic              s_valid,
   input  logic              sof,
   output logic [DATA_W-1:0] d_out,
   output logic              d_valid,
   output logic              par_err,
   output logic              frame_err,
   output logic              busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [DATA_W-1:0] acc, acc_nxt;
   logic [DATA_W-1:0] d_out_nxt;
   logic              d_valid_nxt, par_err_nxt, frame_err_nxt;
   logic [DATA_W-1:0] shifted;

   // 1 when the word plus its parity bit holds an odd number of ones
   function automatic logic odd_parity(input logic [DATA_W-1:0] w, input logic b);
      return (^w) ^ b;
   endfunction

   assign shifted = {acc[DATA_W-2:0], s_in};
   assign busy    = (state != IDLE);

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      acc_nxt       = acc;
      d_out_nxt     = d_out;
      par_err_nxt   = par_err;
      d_valid_nxt   = 1'b0;
      frame_err_nxt = 1'b0;
      if (s_valid) begin
         if (sof) begin
            // sof always starts a new frame; inside a frame it also aborts the old one
            acc_nxt       = {{(DATA_W-1){1'b0}}, s_in};
            cnt_nxt       = CNT_W'(1);
            state_nxt     = DATA;
            frame_err_nxt = (state != IDLE);
         end else begin
            case (state)
               DATA: begin
                  acc_nxt = shifted;
                  cnt_nxt = cnt + CNT_W'(1);
                  if (cnt == LAST_IDX) begin
                     if (PARITY_EN) begin
                        state_nxt = PARITY;
                     end else begin
                        d_out_nxt   = shifted;
                        par_err_nxt = 1'b0;
                        d_valid_nxt = 1'b1;
                        cnt_nxt     = '0;
                        state_nxt   = IDLE;
                     end
                  end
               end
               PARITY: begin
                  d_out_nxt   = acc;
                  par_err_nxt = odd_parity(acc, s_in);
                  d_valid_nxt = 1'b1;
                  cnt_nxt     = '0;
                  state_nxt   = IDLE;
               end
               default: state_nxt = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         acc       <= '0;
         d_out     <= '0;
         d_valid   <= 1'b0;
         par_err   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         acc       <= acc_nxt;
         d_out     <= d_out_nxt;
         d_valid   <= d_valid_nxt;
         par_err   <= par_err_nxt;
         frame_err <= frame_err_nxt;
      end
   end

endmodule

// File: doc/serial_rx_8.md
Name: serial_rx_8

Overview:
Serial-in/parallel-out receiver for the 8-bit shift register path. It consumes the MSB-first bit stream that the shift register produces on shift-left, one bit per qualified cycle. It reassembles each word, checks an optional even-parity bit, and presents the parallel word with a one-cycle valid pulse. It sits directly downstream of the shift register's d_out[7] tap and provides the loopback and check point for that stage.

Parameters:
DATA_W, 8, word width in bits; legal range 2..16.
PARITY_EN, 1, 1 = a parity bit follows the data bits; 0 = no parity bit.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
s_in  input  1  serial data bit, MSB of each word first
s_valid  input  1  s_in is sampled only in cycles where this is 1
sof  input  1  start of frame; qualified by s_valid; marks the current bit as data bit DATA_W-1
d_out  output  DATA_W  last completed word; held until the next word completes
d_valid  output  1  one-cycle pulse when d_out updates
par_err  output  1  parity result for the current d_out; valid with d_valid, held afterwards
frame_err  output  1  one-cycle pulse when a frame is aborted by an early sof
busy  output  1  high while a frame is in progress (state != IDLE)

Behaviour:
- Reset: clk and rst as fixed above; reset is synchronous and active-high. On rst: state=IDLE, bit counter=0, shift accumulator=0, d_out=0, d_valid=0, par_err=0, frame_err=0, busy=0. rst has priority over every other input. Reset mid-frame discards the partial word and produces no d_valid.
- States: IDLE, DATA, PARITY.
- IDLE:
  - s_valid&sof: acc={0..,s_in}, cnt=1, go to DATA.
  - s_valid without sof: bit ignored, stay in IDLE.
- DATA, on s_valid&!sof: acc={acc[DATA_W-2:0],s_in}, cnt=cnt+1.
  - On the bit that makes cnt==DATA_W with PARITY_EN=1: go to PARITY.
  - On the same bit with PARITY_EN=0: commit the word and go to IDLE.
- PARITY, on s_valid&!sof: par_err = (^acc) ^ s_in, which is 1 when the total count of ones is odd. Commit the word and go to IDLE.
- Commit: d_out<=completed word, d_valid<=1 for exactly one cycle.
  - With PARITY_EN=0, par_err<=0.
  - d_valid is registered. It is high in the cycle after the clock edge that sampled the final bit: latency 1 cycle from the last sampled bit.
- s_valid=0 in DATA or PARITY: hold all state. Gaps between bits may be any length.
- Early sof (s_valid&sof while in DATA or PARITY):
  - frame_err pulses for 1 cycle.
  - The partial word is dropped with no d_valid.
  - The current bit starts a new frame: acc={0..,s_in}, cnt=1, state=DATA.
- Back-to-back frames: after a commit the FSM is in IDLE, so the next cycle's s_valid&sof is accepted. A commit and a new sof on the same edge cannot occur.
- A d_valid pulse and a frame_err pulse are never high in the same cycle.
- Counter width: clog2(DATA_W+1). cnt never exceeds DATA_W.
- d_out, par_err: outputs change only on commit or reset.

Test Plan:
- Reset, then sof at 0xA5 (bits 1,0,1,0,0,1,0,1), s_valid continuous, parity bit 0. Expect: d_out=0xA5 and d_valid=1 exactly one cycle after the parity bit; par_err=0; busy high from the cycle after sof through the parity sample.
- 0x3C followed by parity bit 1 (odd total). Expect: d_valid with d_out=0x3C, par_err=1.
- 0x81 with s_valid toggling 1,0,0,1,... (bits separated by idle cycles). Expect: identical result to the continuous stream (d_out=0x81, par_err=0); no extra d_valid pulses.
- Start 0xFF, assert sof again at the 5th bit, then send 0x12 plus parity 0. Expect: frame_err pulses once at the cycle after the early sof; no d_valid for the dropped word; then d_out=0x12, par_err=0.
- Assert rst during bit 4 of a frame. Expect: all outputs 0 on the next cycle; no d_valid; the following sof frame with 0x55 and parity 0 decodes correctly.
- PARITY_EN=0, two back-to-back frames 0x01 and 0xFE (sof on the cycle immediately after the first commit). Expect: two d_valid pulses 8 cycles apart, d_out=0x01 then 0xFE, par_err=0.
